// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes (digits + CR/LF, preset letters,
// pause key) into one-cycle command pulses for the timer core.
module uart_cmd_decoder #(
  parameter int MAX_MIN        = 99,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [6:0] cmd_minutes,
  output logic       cmd_load,
  output logic [1:0] cmd_sel,
  output logic       sel_load,
  output logic       cmd_pause,
  output logic       err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE     = TW'(1);
  localparam logic [6:0]    MAX_ACC     = 7'(MAX_MIN);
  localparam logic [6:0]    RST_MINUTES = 7'd25;

  typedef enum logic {ST_WAIT = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [7:0]      byte_r, byte_s;
  logic [6:0]      acc_r, acc_s;
  logic [1:0]      dcount_r, dcount_s;
  logic            ovf_r, ovf_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic [6:0]      minutes_r, minutes_s;
  logic [1:0]      sel_r, sel_s;
  logic            load_r, load_s;
  logic            sel_load_r, sel_load_s;
  logic            pause_r, pause_s;
  logic            err_r, err_s;
  logic            pop_s;
  logic            busy_s;
  logic            is_digit_s;
  logic            is_term_s;
  logic [7:0]      byte_lc_s;
  logic [3:0]      digit_s;

  assign is_digit_s = (byte_r >= 8'h30) && (byte_r <= 8'h39);
  assign is_term_s  = (byte_r == 8'h0D) || (byte_r == 8'h0A);
  // Folding bit 5 makes upper- and lower-case letters compare equal.
  assign byte_lc_s  = byte_r | 8'h20;
  assign digit_s    = byte_r[3:0];
  assign busy_s     = (dcount_r != 2'd0) || ovf_r;

  assign rd_uart     = pop_s;
  assign busy        = busy_s;
  assign cmd_minutes = minutes_r;
  assign cmd_sel     = sel_r;
  assign cmd_load    = load_r;
  assign sel_load    = sel_load_r;
  assign cmd_pause   = pause_r;
  assign err         = err_r;

  // Next-state, pop strobe, timeout and byte decode.
  always_comb begin
    state_s    = state_r;
    pop_s      = 1'b0;
    byte_s     = byte_r;
    acc_s      = acc_r;
    dcount_s   = dcount_r;
    ovf_s      = ovf_r;
    tmo_s      = tmo_r;
    minutes_s  = minutes_r;
    sel_s      = sel_r;
    load_s     = 1'b0;
    sel_load_s = 1'b0;
    pause_s    = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (!rx_empty && reset_n) begin
          // A pop always beats a timeout landing in the same cycle.
          pop_s   = 1'b1;
          byte_s  = r_data;
          tmo_s   = '0;
          state_s = ST_EXEC;
        end else if (busy_s) begin
          if (tmo_r == TMO_LAST) begin
            acc_s    = 7'd0;
            dcount_s = 2'd0;
            ovf_s    = 1'b0;
            tmo_s    = '0;
            err_s    = 1'b1;
          end else begin
            tmo_s = tmo_r + TMO_ONE;
          end
        end else begin
          tmo_s = '0;
        end
      end
      ST_EXEC: begin
        state_s = ST_WAIT;
        if (is_digit_s) begin
          if (ovf_r) begin
            ovf_s = 1'b1;
          end else if (dcount_r == 2'd2) begin
            ovf_s = 1'b1;
          end else begin
            acc_s    = (acc_r * 7'd10) + {3'b000, digit_s};
            dcount_s = dcount_r + 2'd1;
          end
        end else if (is_term_s) begin
          acc_s    = 7'd0;
          dcount_s = 2'd0;
          ovf_s    = 1'b0;
          if (ovf_r) begin
            err_s = 1'b1;
          end else if (dcount_r == 2'd0) begin
            err_s = 1'b0;
          end else if ((acc_r == 7'd0) || (acc_r > MAX_ACC)) begin
            err_s = 1'b1;
          end else begin
            minutes_s = acc_r;
            load_s    = 1'b1;
          end
        end else begin
          acc_s    = 7'd0;
          dcount_s = 2'd0;
          ovf_s    = 1'b0;
          case (byte_lc_s)
            8'h61:   begin sel_s = 2'd0; sel_load_s = 1'b1; end
            8'h62:   begin sel_s = 2'd1; sel_load_s = 1'b1; end
            8'h63:   begin sel_s = 2'd2; sel_load_s = 1'b1; end
            8'h64:   begin sel_s = 2'd3; sel_load_s = 1'b1; end
            8'h70:   pause_s = 1'b1;
            default: err_s = 1'b1;
          endcase
        end
      end
      default: state_s = ST_WAIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, timeout counter and registered command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_r     <= 8'h00;
      acc_r      <= 7'd0;
      dcount_r   <= 2'd0;
      ovf_r      <= 1'b0;
      tmo_r      <= '0;
      minutes_r  <= RST_MINUTES;
      sel_r      <= 2'd0;
      load_r     <= 1'b0;
      sel_load_r <= 1'b0;
      pause_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      byte_r     <= byte_s;
      acc_r      <= acc_s;
      dcount_r   <= dcount_s;
      ovf_r      <= ovf_s;
      tmo_r      <= tmo_s;
      minutes_r  <= minutes_s;
      sel_r      <= sel_s;
      load_r     <= load_s;
      sel_load_r <= sel_load_s;
      pause_r    <= pause_s;
      err_r      <= err_s;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: a byte-level reference model predicts
// pops, busy and command pulses; a separate monitor checks the pulses.
module tb_uart_cmd_decoder;

  localparam int MAXM = 60;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart, cmd_load, sel_load, cmd_pause, err, busy;
  logic [6:0] cmd_minutes;
  logic [1:0] cmd_sel;

  uart_cmd_decoder #(.MAX_MIN(MAXM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .cmd_minutes(cmd_minutes), .cmd_load(cmd_load),
    .cmd_sel(cmd_sel), .sel_load(sel_load), .cmd_pause(cmd_pause),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; longint cyc; } exp_t;  // kind: 0 load,1 sel,2 pause,3 err

  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  int         ent[$];          // pending digits; a third element marks overflow
  longint     cyc = 0;
  longint     next_pop = 0;
  longint     deadline = -1;
  longint     pend_cyc = -1;
  bit         pend_busy = 1'b0;
  bit         exp_busy = 1'b0;
  int         minutes_m = 25;
  int         sel_m = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] letters [10] = '{"a", "b", "c", "d", "A", "B", "C", "D", "p", "P"};

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, expv);
    end
  endtask

  task automatic push_exp(input int kind, input int val, input longint c);
    exp_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Reference model: effect of one popped byte, visible two cycles later.
  task automatic model_byte(input logic [7:0] b, input longint c);
    int v;
    if (b >= "0" && b <= "9") begin
      if (ent.size() < 2) ent.push_back(int'(b) - 48);
      else if (ent.size() == 2) ent.push_back(-1);
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (ent.size() == 3) push_exp(3, 0, c + 2);
      else if (ent.size() > 0) begin
        v = 0;
        foreach (ent[i]) v = v * 10 + ent[i];
        if (v >= 1 && v <= MAXM) begin
          minutes_m = v;
          push_exp(0, v, c + 2);
        end else push_exp(3, 0, c + 2);
      end
      ent.delete();
    end else begin
      ent.delete();
      case (b)
        "a", "A": begin sel_m = 0; push_exp(1, 0, c + 2); end
        "b", "B": begin sel_m = 1; push_exp(1, 1, c + 2); end
        "c", "C": begin sel_m = 2; push_exp(1, 2, c + 2); end
        "d", "D": begin sel_m = 3; push_exp(1, 3, c + 2); end
        "p", "P": push_exp(2, 0, c + 2);
        default:  push_exp(3, 0, c + 2);
      endcase
    end
    pend_busy = (ent.size() > 0);
    pend_cyc  = c + 2;
    deadline  = pend_busy ? (c + 1 + TMO) : -1;
  endtask

  // One clock cycle: drive FIFO head, predict/check pop and busy, advance.
  task automatic run_cycle();
    bit exp_pop;
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    @(negedge clk);
    exp_pop = reset_n && (fifo.size() > 0) && (cyc >= next_pop);
    chk("rd_uart", rd_uart, exp_pop);
    if (cyc == pend_cyc) exp_busy = pend_busy;
    chk("busy", busy, exp_busy);
    if (exp_pop) begin
      model_byte(fifo[0], cyc);
      next_pop = cyc + 2;
    end else if (reset_n && ent.size() > 0 && cyc == deadline) begin
      push_exp(3, 0, cyc + 1);
      ent.delete();
      pend_busy = 1'b0;
      pend_cyc  = cyc + 1;
      deadline  = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_pop) void'(fifo.pop_front());
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    fifo.delete(); exp_q.delete(); ent.delete();
    minutes_m = 25; sel_m = 0; next_pop = 0; deadline = -1;
    pend_cyc = -1; pend_busy = 1'b0; exp_busy = 1'b0;
    run_cycles(n);
    reset_n = 1'b1;
  endtask

  task automatic check_regs();
    chk("cmd_minutes", cmd_minutes, minutes_m);
    chk("cmd_sel", cmd_sel, sel_m);
  endtask

  task automatic feed(input string s);
    for (int k = 0; k < s.len(); k++) fifo.push_back(s[k]);
  endtask

  // Monitor: compares every presented pulse against the scoreboard queue.
  int   npulse;
  int   dkind;
  exp_t e;
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_minutes", cmd_minutes, 25);
      chk("rst_sel", cmd_sel, 0);
      chk("rst_pulses", {cmd_load, sel_load, cmd_pause, err}, 0);
    end else begin
      npulse = int'(cmd_load) + int'(sel_load) + int'(cmd_pause) + int'(err);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missing_pulse kind=%0d due=%0d now=%0d", e.kind, e.cyc, cyc);
      end
      if (npulse > 0) begin
        checks++;
        if (npulse > 1) begin
          failures++;
          $display("FAIL onehot cyc=%0d pulses=%0d expected=1", cyc, npulse);
        end
        dkind = cmd_load ? 0 : (sel_load ? 1 : (cmd_pause ? 2 : 3));
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++; failures++;
          $display("FAIL unexpected_pulse cyc=%0d kind=%0d expected=none", cyc, dkind);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", dkind, e.kind);
          if (e.kind == 0) chk("load_minutes", cmd_minutes, e.val);
          if (e.kind == 1) chk("sel_value", cmd_sel, e.val);
        end
      end
    end
  end

  initial begin
    int r;
    int g;
    logic [7:0] b;
    do_reset(3);
    run_cycles(2);
    check_regs();
    // "4","5",CR -> 45
    feed("45\r");  run_cycles(10); check_regs();
    // "1","2","3",LF -> overflow error
    feed("123\n"); run_cycles(12); check_regs();
    // "0",CR then "c"
    feed("0\rc");  run_cycles(10); check_regs();
    // range boundaries with MAX_MIN=60
    feed("60\r");  run_cycles(10); check_regs();
    feed("61\n");  run_cycles(10); check_regs();
    feed("9\n\r"); run_cycles(10); check_regs();
    // digit then idle past the timeout, then a lone CR
    feed("7");     run_cycles(25);
    feed("\r");    run_cycles(6);  check_regs();
    // pause then junk back-to-back
    feed("Px");    run_cycles(8);
    // reset in the middle of an entry
    feed("3");     run_cycles(4);
    do_reset(2);
    feed("\r");    run_cycles(6);  check_regs();
    // reset while the popped byte is being decoded
    feed("b");     run_cycle();
    do_reset(2);
    run_cycles(6); check_regs();
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 60) b = ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
      else if (r < 80) b = letters[$urandom_range(0, 9)];
      else             b = 8'($urandom_range(0, 255));
      fifo.push_back(b);
      g = $urandom_range(0, 9);
      if (g == 0)     run_cycles(TMO + $urandom_range(0, 6));
      else if (g < 5) run_cycles(g);
      if (i % 50 == 49) begin
        while (fifo.size() > 0) run_cycle();
        run_cycles(4);
        check_regs();
      end
    end
    while (fifo.size() > 0) run_cycle();
    run_cycles(TMO + 8);
    check_regs();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 99, meaning the largest legal custom duration in minutes (1..99).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning the idle cycles after which a partial entry is abandoned (1 s at 100 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port rx_empty, input, 1 bit, high when the UART receive FIFO holds no byte.
REQ-006 The block SHALL have port r_data, input, 8 bits, the FIFO head byte, valid whenever rx_empty=0.
REQ-007 The block SHALL have port rd_uart, output, 1 bit, a one-cycle pop strobe to the FIFO.
REQ-008 The block SHALL have port cmd_minutes, output, 7 bits, the last accepted custom duration in minutes.
REQ-009 The block SHALL have port cmd_load, output, 1 bit, a one-cycle pulse when cmd_minutes is updated.
REQ-010 The block SHALL have port cmd_sel, output, 2 bits, the last accepted preset selector.
REQ-011 The block SHALL have port sel_load, output, 1 bit, a one-cycle pulse when cmd_sel is updated.
REQ-012 The block SHALL have port cmd_pause, output, 1 bit, a one-cycle start/pause toggle pulse.
REQ-013 The block SHALL have port err, output, 1 bit, a one-cycle pulse on any rejected input or timeout.
REQ-014 The block SHALL have port busy, output, 1 bit, high while a digit entry is pending (dcount>0 or ovf).

Function
REQ-015 The FSM SHALL have exactly two states: WAIT and EXEC.
REQ-016 In WAIT with rx_empty=0, the block SHALL assert rd_uart combinationally in that cycle, capture r_data into byte_q, and go to EXEC.
REQ-017 In EXEC, the block SHALL hold rd_uart=0, decode byte_q, and return to WAIT; throughput is therefore at most one byte per 2 cycles.
REQ-018 All pulse outputs SHALL be registered and high for exactly the one cycle after EXEC, i.e. 2 cycles after the pop edge.
REQ-019 For a digit '0'-'9' (0x30-0x39) with dcount<2 and ovf=0, the block SHALL set acc = acc*10 + digit and increment dcount.
REQ-020 For a digit with dcount=2, the block SHALL set ovf=1 and discard the digit; no error is reported until a terminator arrives.
REQ-021 For a digit with ovf=1 already set, the block SHALL discard it and change no other state.
REQ-022 For CR (0x0D) or LF (0x0A) with ovf=0, dcount>=1 and 1<=acc<=MAX_MIN, the block SHALL set cmd_minutes=acc and pulse cmd_load.
REQ-023 For CR or LF with ovf=1, or acc=0, or acc>MAX_MIN, the block SHALL pulse err and leave cmd_minutes unchanged.
REQ-024 For CR or LF with dcount=0 and ovf=0, the block SHALL take no action and pulse nothing, so CR LF pairs are harmless.
REQ-025 After any terminator, the block SHALL clear acc, dcount and ovf.
REQ-026 For 'a'/'b'/'c'/'d' (either case), the block SHALL set cmd_sel to 0/1/2/3 respectively, pulse sel_load, and clear any pending entry.
REQ-027 For 'p' or 'P', the block SHALL pulse cmd_pause and clear any pending entry.
REQ-028 For any other byte, the block SHALL pulse err and clear any pending entry.
REQ-029 The timeout counter SHALL count cycles in WAIT while busy=1, clear on every pop, and hold at 0 when busy=0.
REQ-030 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL clear acc, dcount and ovf and pulse err in the next cycle.
REQ-031 If a pop and the timeout occur in the same cycle, the pop SHALL win: no timeout error, and the byte is processed normally.
REQ-032 acc SHALL be 7 bits, and its arithmetic SHALL never overflow, since at most 2 digits are accumulated (max 99).
REQ-033 At most one pulse output SHALL be high in any cycle.

Reset
REQ-034 While reset_n=0, regardless of clk, the block SHALL force state=WAIT, rd_uart=0, cmd_minutes=25, cmd_sel=0, all pulses=0, acc=0, dcount=0, ovf=0, timeout counter=0 and busy=0.
REQ-035 A reset asserted mid-entry or during EXEC SHALL discard the byte being processed; that byte is not re-read.
REQ-036 After reset_n deasserts, the first pop SHALL occur on the first cycle in which rx_empty=0.

Verification
REQ-037 Feed "4","5",CR -> three rd_uart strobes, each 1 cycle; cmd_minutes=45; a single cmd_load pulse 2 cycles after the CR pop; err never asserts.
REQ-038 Feed "1","2","3",LF -> err pulses once after LF; cmd_minutes remains 25; busy=1 from the '1' until LF processed.
REQ-039 Feed "0",CR, then "c" -> err after CR; then cmd_sel=2 with a sel_load pulse; cmd_minutes remains 25.
REQ-040 With TIMEOUT_CYCLES=20, feed "7" then idle 25 cycles -> err pulses once, busy falls; a following CR produces no pulse.
REQ-041 Feed "P" followed immediately by "x" back-to-back (rx_empty=0 continuously) -> pops 2 cycles apart; cmd_pause pulse then err pulse, never in the same cycle.
REQ-042 Assert reset_n=0 between "3" and CR -> outputs at reset values; the CR processed after reset yields no pulse.
